memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MIPS pipeline MEM stage; consumes execute_data_t from the execute stage.
//  Issues LW/SW to the data bus through a valid/data_ok handshake and stalls upstream until the bus completes.
//  Produces the registered writeback triple (we, wa, wd) for the regfile.
//  Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ without data_ok before bus_err; must be >=1
// PORTS
//  clk               in   1   clock; all state changes on posedge
//  reset             in   1   synchronous, active-high reset
//  mem_enable        in   1   upstream has a valid execute_data_t this cycle
//  execute_data_reg  in   execute_data_t   fields used: mem_to_reg, mem_write, reg_write, reg_dst, alu_result, rt, rd
//  store_data        in   32  rt value for SW
//  stall             out  1   freeze upstream (execute/decode/fetch)
//  dreq_valid        out  1   data-bus request valid
//  dreq_write        out  1   1=store, 0=load
//  dreq_addr         out  32  byte address = alu_result
//  dreq_wdata        out  32  store data
//  dreq_strobe       out  4   4'hF on store, 4'h0 on load
//  dresp_data_ok     in   1   bus completes the access this cycle
//  dresp_rdata       in   32  load data, valid with data_ok
//  wb_we             out  1   regfile write enable
//  wb_wa             out  5   creg_addr_t dest
//  wb_wd             out  32  write data
//  addr_err          out  1   1-cycle pulse: misaligned LW/SW dropped
//  bus_err           out  1   1-cycle pulse: timeout, access dropped
// BEHAVIOUR
//  - Reset: state=IDLE, wait_cnt=0, captured op cleared. All outputs 0; stall=0.
//  - Capture: at a posedge with mem_enable && !stall, latch execute_data_reg and store_data.
//    mem_op = mem_to_reg | mem_write.
//  - wa = reg_dst ? rd : rt.
//  - wd = mem_to_reg ? captured load data : alu_result.
//  - States: IDLE, REQ.
//  - IDLE, non-mem capture: next edge registers wb_we=reg_write, wb_wa, wb_wd=alu_result. Latency is 1 cycle.
//  - IDLE, mem capture, alu_result[1:0]!=0: no bus request. Next cycle addr_err=1 and wb_we=0. State stays IDLE.
//  - IDLE, mem capture, aligned: state goes to REQ on that edge.
//  - REQ: dreq_valid=1, with addr/write/wdata/strobe held stable from the captured op.
//    stall = (state==REQ) && !dresp_data_ok (combinational).
//  - REQ with data_ok: on that edge, register wb_we=reg_write (0 for SW), wb_wa, and wb_wd (rdata for LW).
//    State returns to IDLE and wait_cnt clears.
//    Upstream may capture a new op on the same edge, so back-to-back ops are legal.
//  - data_ok in the first REQ cycle gives 1-cycle bus latency. dresp_data_ok is ignored outside REQ.
//  - Timeout: wait_cnt increments each REQ cycle without data_ok.
//    When wait_cnt==TIMEOUT_CYCLES-1 and no data_ok: next edge pulses bus_err=1, wb_we=0, state=IDLE, dreq_valid drops.
//    data_ok in that same cycle wins over the timeout.
//  - wb_* outputs hold for one cycle only. wb_we is 0 on every cycle that does not retire an op, including stall cycles.
//  - wb_wa==0 with wb_we=1 is allowed; regfile ignores r0.
//  - Reset in REQ: dreq_valid=0 the next cycle. The outstanding access is discarded with no writeback and no err pulse.
//  - mem_enable=0 in IDLE: no capture; outputs idle next cycle.
// TESTING
//  1. ADDI retire: alu_result=32'h5, rt=8, reg_write=1 -> next cycle wb_we=1, wb_wa=8, wb_wd=5; stall never high.
//  2. LW, 3-cycle bus: addr=32'h100, data_ok on 3rd REQ cycle, rdata=32'hDEADBEEF -> stall high for 2 cycles;
//     dreq_valid high 3 cycles; then wb_we=1, wb_wd=32'hDEADBEEF.
//  3. SW, 0-wait: addr=32'h104, store_data=32'h1234, data_ok in 1st REQ cycle -> dreq_write=1, strobe=4'hF;
//     stall never high; wb_we=0.
//  4. Misaligned LW at 32'h102 -> dreq_valid stays 0; addr_err pulse 1 cycle; wb_we=0; next op proceeds normally.
//  5. TIMEOUT_CYCLES=4, no data_ok -> dreq_valid 4 cycles, then bus_err pulse; stall drops; wb_we=0.
//  6. Reset asserted in 2nd REQ cycle of a LW -> next cycle dreq_valid=0, stall=0, wb_we=0, no err pulses.
//     Then back-to-back LW, LW with 1-cycle data_ok -> two writebacks on consecutive retire edges.

Source files
------------

// File: rtl/memory_stage_if.sv
// Shared types for the MEM stage and the valid/data_ok data-bus interface it drives.
// The package lives here so that it is compiled before both the interface and the stage.
package memory_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [REG_W-1:0] creg_addr_t;

    typedef struct packed {
        logic              mem_to_reg;
        logic              mem_write;
        logic              reg_write;
        logic              reg_dst;
        logic [DATA_W-1:0] alu_result;
        creg_addr_t        rt;
        creg_addr_t        rd;
    } execute_data_t;

endpackage

interface memory_stage_if;
    import memory_stage_pkg::*;

    logic              dreq_valid;
    logic              dreq_write;
    logic [DATA_W-1:0] dreq_addr;
    logic [DATA_W-1:0] dreq_wdata;
    logic [3:0]        dreq_strobe;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_rdata;

    modport master (
        output dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strobe,
        input  dresp_data_ok, dresp_rdata
    );

    modport slave (
        input  dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strobe,
        output dresp_data_ok, dresp_rdata
    );

endinterface

// File: rtl/memory_stage.sv
// MIPS MEM stage: issues LW/SW on the data bus, stalls upstream until completion,
// and produces a one-cycle registered writeback; flags misaligned accesses and bus timeouts.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_enable,
    input  execute_data_t       execute_data_reg,
    input  logic [DATA_W-1:0]   store_data,
    output logic                stall,
    memory_stage_if.master      dbus,
    output logic                wb_we,
    output creg_addr_t          wb_wa,
    output logic [DATA_W-1:0]   wb_wd,
    output logic                addr_err,
    output logic                bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    execute_data_t     op_q,      op_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;

    // One-entry holding slot for a non-memory op captured on the same edge a memory op retires.
    logic              pend_vld_q, pend_vld_d;
    logic              pend_we_q,  pend_we_d;
    creg_addr_t        pend_wa_q,  pend_wa_d;
    logic [DATA_W-1:0] pend_wd_q,  pend_wd_d;

    logic              wb_we_q,    wb_we_d;
    creg_addr_t        wb_wa_q,    wb_wa_d;
    logic [DATA_W-1:0] wb_wd_q,    wb_wd_d;
    logic              addr_err_q, addr_err_d;
    logic              bus_err_q,  bus_err_d;

    logic              req_active;
    logic              capture;
    logic              in_mem;
    logic              in_misaligned;
    creg_addr_t        in_wa;
    creg_addr_t        op_wa;
    logic              slot_busy;

    assign req_active = (state_q == REQ);
    assign stall      = req_active && !dbus.dresp_data_ok;

    // Bus request fields are driven from the captured op and forced idle outside REQ.
    assign dbus.dreq_valid  = req_active;
    assign dbus.dreq_write  = req_active && op_q.mem_write;
    assign dbus.dreq_addr   = req_active ? op_q.alu_result : '0;
    assign dbus.dreq_wdata  = (req_active && op_q.mem_write) ? wdata_q : '0;
    assign dbus.dreq_strobe = (req_active && op_q.mem_write) ? 4'hF : 4'h0;

    assign wb_we    = wb_we_q;
    assign wb_wa    = wb_wa_q;
    assign wb_wd    = wb_wd_q;
    assign addr_err = addr_err_q;
    assign bus_err  = bus_err_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        pend_vld_d = 1'b0;
        pend_we_d  = pend_we_q;
        pend_wa_d  = pend_wa_q;
        pend_wd_d  = pend_wd_q;
        wb_we_d    = 1'b0;
        wb_wa_d    = '0;
        wb_wd_d    = '0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        slot_busy  = 1'b0;

        capture       = mem_enable && !stall;
        in_mem        = execute_data_reg.mem_to_reg | execute_data_reg.mem_write;
        in_misaligned = |execute_data_reg.alu_result[1:0];
        in_wa         = execute_data_reg.reg_dst ? execute_data_reg.rd : execute_data_reg.rt;
        op_wa         = op_q.reg_dst ? op_q.rd : op_q.rt;

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    wb_we_d   = pend_we_q;
                    wb_wa_d   = pend_wa_q;
                    wb_wd_d   = pend_wd_q;
                    slot_busy = 1'b1;
                end
            end
            REQ: begin
                if (dbus.dresp_data_ok) begin
                    wb_we_d   = op_q.reg_write & ~op_q.mem_write;
                    wb_wa_d   = op_wa;
                    wb_wd_d   = op_q.mem_to_reg ? dbus.dresp_rdata : op_q.alu_result;
                    slot_busy = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new op may enter from IDLE or on the retire edge of a bus access.
        if (capture) begin
            op_d    = execute_data_reg;
            wdata_d = store_data;
            if (!in_mem) begin
                if (slot_busy) begin
                    pend_vld_d = 1'b1;
                    pend_we_d  = execute_data_reg.reg_write;
                    pend_wa_d  = in_wa;
                    pend_wd_d  = execute_data_reg.alu_result;
                end else begin
                    wb_we_d = execute_data_reg.reg_write;
                    wb_wa_d = in_wa;
                    wb_wd_d = execute_data_reg.alu_result;
                end
            end else if (in_misaligned) begin
                addr_err_d = 1'b1;
            end else begin
                state_d = REQ;
                cnt_d   = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            wdata_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_we_q  <= 1'b0;
            pend_wa_q  <= '0;
            pend_wd_q  <= '0;
            wb_we_q    <= 1'b0;
            wb_wa_q    <= '0;
            wb_wd_q    <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            pend_vld_q <= pend_vld_d;
            pend_we_q  <= pend_we_d;
            pend_wa_q  <= pend_wa_d;
            pend_wd_q  <= pend_wd_d;
            wb_we_q    <= wb_we_d;
            wb_wa_q    <= wb_wa_d;
            wb_wd_q    <= wb_wd_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: table-driven ops with a writeback scoreboard, plus
// hand-written reset-in-REQ and back-to-back load sequences.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_enable;
    execute_data_t exd;
    logic [31:0]   store_data;
    logic          stall;
    logic          wb_we;
    creg_addr_t    wb_wa;
    logic [31:0]   wb_wd;
    logic          addr_err;
    logic          bus_err;

    memory_stage_if dbus ();

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_enable       (mem_enable),
        .execute_data_reg (exd),
        .store_data       (store_data),
        .stall            (stall),
        .dbus             (dbus),
        .wb_we            (wb_we),
        .wb_wa            (wb_wa),
        .wb_wd            (wb_wd),
        .addr_err         (addr_err),
        .bus_err          (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        creg_addr_t wa;
        logic [31:0] wd;
        logic       ae;
        logic       be;
    } exp_t;

    typedef struct {
        logic        m2r;
        logic        mw;
        logic        rw;
        logic        rdst;
        logic [31:0] alu;
        creg_addr_t  rt;
        creg_addr_t  rd;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_ev;
        logic        exp_we;
        creg_addr_t  exp_wa;
        logic [31:0] exp_wd;
        logic        exp_ae;
        logic        exp_be;
        int          exp_valid;
        int          exp_stall;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    exp_t sbq [$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every writeback or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (wb_we || addr_err || bus_err) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual we=%0b wa=%0d wd=%h ae=%0b be=%0b required none",
                         wb_we, wb_wa, wb_wd, addr_err, bus_err);
            end else begin
                mon_e = sbq.pop_front();
                if (wb_we !== mon_e.we || addr_err !== mon_e.ae || bus_err !== mon_e.be ||
                    (mon_e.we && (wb_wa !== mon_e.wa || wb_wd !== mon_e.wd))) begin
                    failures++;
                    $display("FAIL sb_event actual we=%0b wa=%0d wd=%h ae=%0b be=%0b required we=%0b wa=%0d wd=%h ae=%0b be=%0b",
                             wb_we, wb_wa, wb_wd, addr_err, bus_err,
                             mon_e.we, mon_e.wa, mon_e.wd, mon_e.ae, mon_e.be);
                end
            end
        end
    end

    task automatic drive_op(input vec_t v);
        mem_enable = 1'b1;
        exd = '{mem_to_reg: v.m2r, mem_write: v.mw, reg_write: v.rw, reg_dst: v.rdst,
                alu_result: v.alu, rt: v.rt, rd: v.rd};
        store_data = v.sdata;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int   nvalid = 0;
        int   nstall = 0;
        logic busbad = 1'b0;
        logic done   = 1'b0;
        @(negedge clk);
        drive_op(v);
        dbus.dresp_data_ok = 1'b0;
        if (v.exp_ev) sbq.push_back('{v.exp_we, v.exp_wa, v.exp_wd, v.exp_ae, v.exp_be});
        @(posedge clk);
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            mem_enable = 1'b0;
            exd = '0;
            dbus.dresp_data_ok = (v.lat != 0) && (n == v.lat);
            dbus.dresp_rdata   = v.rdata;
            #1;
            if (dbus.dreq_valid) begin
                nvalid++;
                if (dbus.dreq_addr !== v.alu || dbus.dreq_write !== v.mw ||
                    dbus.dreq_strobe !== (v.mw ? 4'hF : 4'h0) ||
                    (v.mw && dbus.dreq_wdata !== v.sdata))
                    busbad = 1'b1;
            end else begin
                done = 1'b1;
            end
            if (stall) nstall++;
            if (!done) @(posedge clk);
        end
        dbus.dresp_data_ok = 1'b0;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_valid_cycles", idx), 32'(nvalid), 32'(v.exp_valid));
        chk($sformatf("v%0d_stall_cycles", idx), 32'(nstall), 32'(v.exp_stall));
        if (nvalid > 0) chk($sformatf("v%0d_bus_fields", idx), 32'(busbad), 32'd0);
        chk($sformatf("v%0d_sb_drained", idx), 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t lw;
        reset = 1'b1;
        mem_enable = 1'b0;
        exd = '0;
        store_data = '0;
        dbus.dresp_data_ok = 1'b0;
        dbus.dresp_rdata = '0;

        //        m2r  mw   rw   rdst alu            rt     rd     sdata         rdata          lat ev   we   wa     wd             ae   be  vld stl
        vecs[0]  = '{1'b0,1'b0,1'b1,1'b0,32'h5,        5'd8,  5'd3,  32'h0,        32'h0,         0, 1'b1,1'b1,5'd8,  32'h5,         1'b0,1'b0, 0, 0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,32'hFFFF0001, 5'd2,  5'd17, 32'h0,        32'h0,         0, 1'b1,1'b1,5'd17, 32'hFFFF0001,  1'b0,1'b0, 0, 0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h40,       5'd3,  5'd4,  32'h0,        32'h0,         0, 1'b0,1'b0,5'd0,  32'h0,         1'b0,1'b0, 0, 0};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,32'h100,      5'd9,  5'd0,  32'h0,        32'hDEADBEEF,  3, 1'b1,1'b1,5'd9,  32'hDEADBEEF,  1'b0,1'b0, 3, 2};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h104,      5'd10, 5'd0,  32'h1234,     32'h0,         1, 1'b0,1'b0,5'd0,  32'h0,         1'b0,1'b0, 1, 0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,32'h102,      5'd11, 5'd0,  32'h0,        32'h55,        1, 1'b1,1'b0,5'd0,  32'h0,         1'b1,1'b0, 0, 0};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,32'h7,        5'd4,  5'd0,  32'h0,        32'h0,         0, 1'b1,1'b1,5'd4,  32'h7,         1'b0,1'b0, 0, 0};
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,32'h200,      5'd12, 5'd0,  32'h0,        32'h0,         0, 1'b1,1'b0,5'd0,  32'h0,         1'b0,1'b1, 4, 4};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h201,      5'd13, 5'd0,  32'hAAAA,     32'h0,         1, 1'b1,1'b0,5'd0,  32'h0,         1'b1,1'b0, 0, 0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,32'h300,      5'd0,  5'd0,  32'h0,        32'hCAFE,      1, 1'b1,1'b1,5'd0,  32'hCAFE,      1'b0,1'b0, 1, 0};
        vecs[10] = '{1'b1,1'b0,1'b1,1'b0,32'h7FFC,     5'd14, 5'd0,  32'h0,        32'h13579BDF,  2, 1'b1,1'b1,5'd14, 32'h13579BDF,  1'b0,1'b0, 2, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dreq_valid", 32'(dbus.dreq_valid), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_wd", wb_wd, 32'd0);
        chk("rst_errs", 32'({addr_err, bus_err}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(vecs[i], i);

        // Idle with a stray data_ok: nothing must happen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_enable = 1'b0;
            dbus.dresp_data_ok = 1'b1;
            #1;
            chk($sformatf("idle%0d_valid", i), 32'(dbus.dreq_valid), 32'd0);
            chk($sformatf("idle%0d_stall", i), 32'(stall), 32'd0);
        end
        dbus.dresp_data_ok = 1'b0;

        // Reset in the second REQ cycle of a load discards it silently.
        lw = vecs[3];
        lw.alu = 32'h500;
        @(negedge clk);
        drive_op(lw);
        @(posedge clk);
        @(negedge clk);
        mem_enable = 1'b0;
        #1;
        chk("rr_req1_valid", 32'(dbus.dreq_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rr_req2_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rr_after_valid", 32'(dbus.dreq_valid), 32'd0);
        chk("rr_after_stall", 32'(stall), 32'd0);
        chk("rr_after_wb_we", 32'(wb_we), 32'd0);
        chk("rr_after_errs", 32'({addr_err, bus_err}), 32'd0);
        reset = 1'b0;

        // Back-to-back loads: second captured on the retire edge of the first.
        @(negedge clk);
        lw.alu = 32'h400; lw.rt = 5'd6;
        drive_op(lw);
        sbq.push_back('{1'b1, 5'd6, 32'hA1A1A1A1, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        lw.alu = 32'h404; lw.rt = 5'd7;
        drive_op(lw);
        dbus.dresp_data_ok = 1'b1;
        dbus.dresp_rdata = 32'hA1A1A1A1;
        sbq.push_back('{1'b1, 5'd7, 32'hB2B2B2B2, 1'b0, 1'b0});
        #1;
        chk("b2b_first_addr", dbus.dreq_addr, 32'h400);
        chk("b2b_first_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_enable = 1'b0;
        exd = '0;
        dbus.dresp_rdata = 32'hB2B2B2B2;
        #1;
        chk("b2b_first_wb_we", 32'(wb_we), 32'd1);
        chk("b2b_second_addr", dbus.dreq_addr, 32'h404);
        chk("b2b_second_valid", 32'(dbus.dreq_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        dbus.dresp_data_ok = 1'b0;
        #1;
        chk("b2b_second_wb_we", 32'(wb_we), 32'd1);
        chk("b2b_second_wb_wd", wb_wd, 32'hB2B2B2B2);
        chk("b2b_sb_drained", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("b2b_end_valid", 32'(dbus.dreq_valid), 32'd0);
        chk("b2b_end_wb_we", 32'(wb_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
